// File: rtl/spi_master_driver.sv
// Mode-0 SPI master for a single slave: one comm_start runs one full-duplex
// transfer of NUM_DATA_BITS bits, with SCLK derived from sys_clk by CLOCK_DIV.
module spi_master_driver #(
  parameter int unsigned CLOCK_DIV     = 16,
  parameter bit          SS_ACTIVE_LOW = 1'b1,
  parameter bit          LSB_FIRST     = 1'b0,
  parameter int unsigned NUM_DATA_BITS = 8
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic                     comm_start,
  output logic                     bus_ready,
  output logic                     miso_new_data,
  output logic [NUM_DATA_BITS-1:0] miso_data,
  input  logic [NUM_DATA_BITS-1:0] mosi_data,
  output logic                     ss_out,
  output logic                     sclk_out,
  input  logic                     miso_in,
  output logic                     mosi_out
);

  localparam int unsigned HALF  = CLOCK_DIV / 2;
  localparam int unsigned DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned BIT_W = $clog2(NUM_DATA_BITS + 1);
  localparam logic        SS_ON  = ~SS_ACTIVE_LOW;
  localparam logic        SS_OFF = SS_ACTIVE_LOW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_HOLD
  } state_t;

  state_t                   r_state;
  logic [DIV_W-1:0]         r_div;
  logic [BIT_W-1:0]         r_bits;
  logic [NUM_DATA_BITS-1:0] r_tx;
  logic [NUM_DATA_BITS-1:0] r_rx;

  logic                     w_phase_end;
  logic                     w_first_bit;
  logic [NUM_DATA_BITS-1:0] w_tx_shift;
  logic                     w_tx_next_bit;
  logic [NUM_DATA_BITS-1:0] w_rx_next;

  // Every non-idle state lasts exactly HALF sys_clk cycles.
  assign w_phase_end = (r_div == DIV_W'(HALF - 1));

  // Shift direction follows LSB_FIRST on both lines; zeros fill in behind the
  // TX word so MOSI naturally drops to 0 once the last bit has gone out.
  assign w_first_bit   = LSB_FIRST ? mosi_data[0] : mosi_data[NUM_DATA_BITS-1];
  assign w_tx_shift    = LSB_FIRST ? (r_tx >> 1) : (r_tx << 1);
  assign w_tx_next_bit = LSB_FIRST ? w_tx_shift[0] : w_tx_shift[NUM_DATA_BITS-1];
  assign w_rx_next     = LSB_FIRST
                       ? ((r_rx >> 1) | (NUM_DATA_BITS'(miso_in) << (NUM_DATA_BITS - 1)))
                       : ((r_rx << 1) | NUM_DATA_BITS'(miso_in));

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_div         <= '0;
      r_bits        <= '0;
      r_tx          <= '0;
      r_rx          <= '0;
      bus_ready     <= 1'b1;
      miso_new_data <= 1'b0;
      miso_data     <= '0;
      ss_out        <= SS_OFF;
      sclk_out      <= 1'b0;
      mosi_out      <= 1'b0;
    end else begin
      miso_new_data <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_div <= '0;
          if (comm_start) begin
            r_state   <= S_SETUP;
            r_tx      <= mosi_data;
            r_bits    <= '0;
            mosi_out  <= w_first_bit;
            ss_out    <= SS_ON;
            bus_ready <= 1'b0;
          end
        end
        S_SETUP: begin
          if (w_phase_end) begin
            r_state  <= S_HIGH;
            r_div    <= '0;
            sclk_out <= 1'b1;
            r_rx     <= w_rx_next;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        S_HIGH: begin
          if (w_phase_end) begin
            r_state  <= S_LOW;
            r_div    <= '0;
            sclk_out <= 1'b0;
            r_tx     <= w_tx_shift;
            mosi_out <= w_tx_next_bit;
            r_bits   <= r_bits + BIT_W'(1);
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        S_LOW: begin
          if (w_phase_end) begin
            r_div <= '0;
            if (r_bits == BIT_W'(NUM_DATA_BITS)) begin
              r_state <= S_HOLD;
            end else begin
              r_state  <= S_HIGH;
              sclk_out <= 1'b1;
              r_rx     <= w_rx_next;
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        S_HOLD: begin
          if (w_phase_end) begin
            r_state       <= S_IDLE;
            r_div         <= '0;
            ss_out        <= SS_OFF;
            miso_data     <= r_rx;
            miso_new_data <= 1'b1;
            bus_ready     <= 1'b1;
            mosi_out      <= 1'b0;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_driver.sv
// Directed bench for spi_master_driver: three instances cover MSB-first/16-bit,
// LSB-first with active-high SS, and the minimum clock divider.
module tb_spi_master_driver;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total;
  int bad;

  // Instance A: CLOCK_DIV=16, N=16, MSB first, SS active low
  logic        cs_a, rdy_a, nd_a, ss_a, sclk_a, miso_a, mosi_a;
  logic [15:0] md_a, mo_a;
  spi_master_driver #(.CLOCK_DIV(16), .SS_ACTIVE_LOW(1'b1), .LSB_FIRST(1'b0), .NUM_DATA_BITS(16)) u_a (
    .sys_clk(clk), .rst(rst), .comm_start(cs_a), .bus_ready(rdy_a), .miso_new_data(nd_a),
    .miso_data(md_a), .mosi_data(mo_a), .ss_out(ss_a), .sclk_out(sclk_a),
    .miso_in(miso_a), .mosi_out(mosi_a));

  // Instance B: CLOCK_DIV=4, N=16, LSB first, SS active high
  logic        cs_b, rdy_b, nd_b, ss_b, sclk_b, miso_b, mosi_b;
  logic [15:0] md_b, mo_b;
  spi_master_driver #(.CLOCK_DIV(4), .SS_ACTIVE_LOW(1'b0), .LSB_FIRST(1'b1), .NUM_DATA_BITS(16)) u_b (
    .sys_clk(clk), .rst(rst), .comm_start(cs_b), .bus_ready(rdy_b), .miso_new_data(nd_b),
    .miso_data(md_b), .mosi_data(mo_b), .ss_out(ss_b), .sclk_out(sclk_b),
    .miso_in(miso_b), .mosi_out(mosi_b));

  // Instance C: CLOCK_DIV=2, N=8, MSB first, SS active low
  logic       cs_c, rdy_c, nd_c, ss_c, sclk_c, miso_c, mosi_c;
  logic [7:0] md_c, mo_c;
  spi_master_driver #(.CLOCK_DIV(2), .SS_ACTIVE_LOW(1'b1), .LSB_FIRST(1'b0), .NUM_DATA_BITS(8)) u_c (
    .sys_clk(clk), .rst(rst), .comm_start(cs_c), .bus_ready(rdy_c), .miso_new_data(nd_c),
    .miso_data(md_c), .mosi_data(mo_c), .ss_out(ss_c), .sclk_out(sclk_c),
    .miso_in(miso_c), .mosi_out(mosi_c));

  int          ss_cyc_a, busy_a, hi_a, hi_run_a, run_err_a, pulses_a, nd_cnt_a;
  logic [15:0] cap_a, slv_a;
  int          pulses_b, nd_cnt_b;
  logic [15:0] cap_b, slv_b;
  int          hi_c, hi_run_c, run_err_c, pulses_c, nd_cnt_c;
  logic [7:0]  cap_c, slv_c;

  // Per-cycle activity counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (ss_a === 1'b0) ss_cyc_a++;
    if (rdy_a === 1'b0) busy_a++;
    if (sclk_a === 1'b1) begin hi_a++; hi_run_a++; end
    if (nd_a === 1'b1) nd_cnt_a++;
    if (nd_b === 1'b1) nd_cnt_b++;
    if (sclk_c === 1'b1) begin hi_c++; hi_run_c++; end
    if (nd_c === 1'b1) nd_cnt_c++;
  end

  // Slave models: capture MOSI on SCLK rise, present next MISO bit on SCLK fall.
  always @(posedge sclk_a) begin cap_a = {cap_a[14:0], mosi_a}; pulses_a++; end
  always @(negedge sclk_a) begin
    if (hi_run_a != 8) run_err_a++;
    hi_run_a = 0;
    if (ss_a === 1'b0) begin slv_a = slv_a << 1; miso_a = slv_a[15]; end
  end

  always @(posedge sclk_b) begin cap_b = {mosi_b, cap_b[15:1]}; pulses_b++; end
  always @(negedge sclk_b) begin
    if (ss_b === 1'b1) begin slv_b = slv_b >> 1; miso_b = slv_b[0]; end
  end

  always @(posedge sclk_c) begin cap_c = {cap_c[6:0], mosi_c}; pulses_c++; end
  always @(negedge sclk_c) begin
    if (hi_run_c != 1) run_err_c++;
    hi_run_c = 0;
    if (ss_c === 1'b0) begin slv_c = slv_c << 1; miso_c = slv_c[7]; end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon;
    @(posedge clk);
    ss_cyc_a = 0; busy_a = 0; hi_a = 0; hi_run_a = 0; run_err_a = 0; pulses_a = 0; nd_cnt_a = 0;
    pulses_b = 0; nd_cnt_b = 0;
    hi_c = 0; hi_run_c = 0; run_err_c = 0; pulses_c = 0; nd_cnt_c = 0;
    @(negedge clk);
  endtask

  task automatic start_a(input logic [15:0] tx, input logic [15:0] sl);
    mo_a = tx; slv_a = sl; miso_a = sl[15]; cs_a = 1'b1;
    @(negedge clk);
    cs_a = 1'b0;
  endtask

  task automatic start_b(input logic [15:0] tx, input logic [15:0] sl);
    mo_b = tx; slv_b = sl; miso_b = sl[0]; cs_b = 1'b1;
    @(negedge clk);
    cs_b = 1'b0;
  endtask

  task automatic start_c(input logic [7:0] tx, input logic [7:0] sl);
    mo_c = tx; slv_c = sl; miso_c = sl[7]; cs_c = 1'b1;
    @(negedge clk);
    cs_c = 1'b0;
  endtask

  task automatic wait_nd_a(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (nd_a === 1'b1) begin seen = 1'b1; break; end
    end
    chk({tag, "_done"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_nd_b(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (nd_b === 1'b1) begin seen = 1'b1; break; end
    end
    chk({tag, "_done"}, 32'(seen), 32'd1);
  endtask

  initial begin
    int cnt;
    int nd_before;
    total = 0; bad = 0;
    rst = 1'b0;
    cs_a = 1'b0; cs_b = 1'b0; cs_c = 1'b0;
    mo_a = '0; mo_b = '0; mo_c = '0;
    miso_a = 1'b0; miso_b = 1'b0; miso_c = 1'b0;
    slv_a = '0; slv_b = '0; slv_c = '0;
    cap_a = '0; cap_b = '0; cap_c = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ss_a", 32'(ss_a), 32'd1);
    chk("rst_sclk_a", 32'(sclk_a), 32'd0);
    chk("rst_mosi_a", 32'(mosi_a), 32'd0);
    chk("rst_rdy_a", 32'(rdy_a), 32'd1);
    chk("rst_nd_a", 32'(nd_a), 32'd0);
    chk("rst_md_a", 32'(md_a), 32'd0);
    chk("rst_ss_b", 32'(ss_b), 32'd0);
    chk("rst_rdy_c", 32'(rdy_c), 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic transfer
    clear_mon;
    start_a(16'h0cf7, 16'h4ac5);
    chk("basic_ss_on", 32'(ss_a), 32'd0);
    chk("basic_busy", 32'(rdy_a), 32'd0);
    wait_nd_a("basic");
    chk("basic_miso", 32'(md_a), 32'h4ac5);
    chk("basic_ss_off", 32'(ss_a), 32'd1);
    chk("basic_rdy", 32'(rdy_a), 32'd1);
    repeat (3) @(negedge clk);
    chk("basic_nd_once", 32'(nd_cnt_a), 32'd1);
    chk("basic_mosi_bits", 32'(cap_a), 32'h0cf7);
    chk("basic_pulses", 32'(pulses_a), 32'd16);
    chk("basic_hi_cycles", 32'(hi_a), 32'd128);
    chk("basic_hi_runs", 32'(run_err_a), 32'd0);
    chk("basic_ss_cycles", 32'(ss_cyc_a), 32'd272);
    chk("basic_busy_cycles", 32'(busy_a), 32'd272);

    // Back-to-back, second start issued in the miso_new_data cycle
    clear_mon;
    repeat (5) @(negedge clk);
    start_a(16'h37e1, 16'h16fb);
    wait_nd_a("b2b1");
    chk("b2b1_miso", 32'(md_a), 32'h16fb);
    chk("b2b1_ss_off", 32'(ss_a), 32'd1);
    chk("b2b1_mosi_bits", 32'(cap_a), 32'h37e1);
    start_a(16'h2fa0, 16'h35d9);
    chk("b2b2_accept", 32'(rdy_a), 32'd0);
    wait_nd_a("b2b2");
    chk("b2b2_miso", 32'(md_a), 32'h35d9);
    chk("b2b2_mosi_bits", 32'(cap_a), 32'h2fa0);
    repeat (3) @(negedge clk);
    chk("b2b_nd_count", 32'(nd_cnt_a), 32'd2);
    chk("b2b_pulses", 32'(pulses_a), 32'd32);

    // Busy handling: start pulse and data change mid-transfer are ignored
    repeat (7) @(negedge clk);
    clear_mon;
    start_a(16'h5a3c, 16'hc3a5);
    repeat (40) @(negedge clk);
    cs_a = 1'b1; mo_a = 16'hffff;
    @(negedge clk);
    cs_a = 1'b0;
    wait_nd_a("busy");
    chk("busy_miso", 32'(md_a), 32'hc3a5);
    repeat (50) @(negedge clk);
    chk("busy_mosi_bits", 32'(cap_a), 32'h5a3c);
    chk("busy_busy_cycles", 32'(busy_a), 32'd272);
    chk("busy_nd_count", 32'(nd_cnt_a), 32'd1);
    chk("busy_pulses", 32'(pulses_a), 32'd16);
    chk("busy_ss_idle", 32'(ss_a), 32'd1);
    chk("busy_rdy_idle", 32'(rdy_a), 32'd1);

    // LSB first, SS active high
    start_b(16'h0001, 16'h0001);
    chk("lsb_ss_on", 32'(ss_b), 32'd1);
    chk("lsb_first_mosi", 32'(mosi_b), 32'd1);
    wait_nd_b("lsb1");
    chk("lsb1_miso", 32'(md_b), 32'h0001);
    chk("lsb1_mosi_bits", 32'(cap_b), 32'h0001);
    chk("lsb1_ss_off", 32'(ss_b), 32'd0);
    repeat (4) @(negedge clk);
    start_b(16'hc2b7, 16'h91e4);
    wait_nd_b("lsb2");
    chk("lsb2_miso", 32'(md_b), 32'h91e4);
    chk("lsb2_mosi_bits", 32'(cap_b), 32'hc2b7);
    repeat (2) @(negedge clk);
    chk("lsb_nd_count", 32'(nd_cnt_b), 32'd2);
    chk("lsb_pulses", 32'(pulses_b), 32'd32);

    // Minimum divider: bus_ready returns at E+18
    start_c(8'ha5, 8'h3c);
    chk("div2_busy", 32'(rdy_c), 32'd0);
    cnt = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rdy_c === 1'b1) break;
      cnt++;
    end
    chk("div2_ready_latency", 32'(cnt), 32'd18);
    chk("div2_nd_pulse", 32'(nd_c), 32'd1);
    chk("div2_miso", 32'(md_c), 32'h3c);
    repeat (2) @(negedge clk);
    chk("div2_mosi_bits", 32'(cap_c), 32'ha5);
    chk("div2_pulses", 32'(pulses_c), 32'd8);
    chk("div2_hi_cycles", 32'(hi_c), 32'd8);
    chk("div2_hi_runs", 32'(run_err_c), 32'd0);
    chk("div2_nd_count", 32'(nd_cnt_c), 32'd1);

    // Reset mid-transfer
    start_a(16'hffff, 16'hffff);
    repeat (100) @(negedge clk);
    chk("mid_pre_ss", 32'(ss_a), 32'd0);
    chk("mid_pre_mosi", 32'(mosi_a), 32'd1);
    nd_before = nd_cnt_a;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_ss", 32'(ss_a), 32'd1);
    chk("mid_rst_sclk", 32'(sclk_a), 32'd0);
    chk("mid_rst_mosi", 32'(mosi_a), 32'd0);
    chk("mid_rst_rdy", 32'(rdy_a), 32'd1);
    chk("mid_rst_nd", 32'(nd_a), 32'd0);
    chk("mid_rst_md", 32'(md_a), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (400) @(negedge clk);
    chk("mid_post_nd", 32'(nd_cnt_a), 32'(nd_before));
    chk("mid_post_rdy", 32'(rdy_a), 32'd1);
    chk("mid_post_ss", 32'(ss_a), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
